// File: rtl/dnn_pkg.sv
// Shared constants, state encoding and input-sanitising helpers for the DNN layer sequencer.
package dnn_pkg;

  localparam int F_SIZE    = 1024;
  localparam int N_CORE    = 16;
  localparam int AW        = 11;
  localparam int DRAIN_CYC = 3;

  localparam int SW = AW - 1;               // word-address / input-size width
  localparam int NW = $clog2(N_CORE + 1);   // n_out width
  localparam int IW = $clog2(N_CORE);       // out_idx width
  localparam int CW = $clog2(DRAIN_CYC);    // drain counter width

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    BIAS,
    DRAIN,
    OUT
  } seq_state_t;

  // Zero outputs still produce one word; more than N_CORE cannot exist on the chain.
  function automatic logic [NW-1:0] eff_n_out(input logic [NW-1:0] n);
    if (n == '0) return NW'(1);
    else if (n > NW'(N_CORE)) return NW'(N_CORE);
    else return n;
  endfunction

  // The last bank word holds the bias, so the input vector may not reach it.
  function automatic logic [SW-1:0] clamp_size(input logic [SW-1:0] s);
    if (s > SW'(F_SIZE - 1)) return SW'(F_SIZE - 1);
    else return s;
  endfunction

endpackage

// File: rtl/dnn_out_drain.sv
// OUT-phase engine: steps the core result chain into normalize under valid/ready backpressure.
module dnn_out_drain
  import dnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [NW-1:0] n_out_i,
  input  logic          out_ready_i,
  output logic          norm_en_o,
  output logic          outr_o,
  output logic          update_o,
  output logic          out_valid_o,
  output logic [IW-1:0] out_idx_o,
  output logic          last_done_o
);

  logic          active_q, active_d;
  logic [NW-1:0] j_q, j_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;
  logic          adv, step, last_step;

  // NOTE: every signal gets a default before the case logic so no latch is inferred.
  always_comb begin
    adv       = !valid_q || out_ready_i;
    step      = active_q && adv;
    last_step = (j_q == n_out_i - NW'(1));

    norm_en_o   = step;
    update_o    = step && (j_q == '0);
    outr_o      = step && !last_step;
    last_done_o = valid_q && out_ready_i && last_q;

    active_d = active_q;
    j_d      = j_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    last_d   = last_q;

    if (start_i) begin
      active_d = 1'b1;
      j_d      = '0;
    end else if (step) begin
      j_d = j_q + NW'(1);
      if (last_step) active_d = 1'b0;
    end

    // A new capture replaces the held word; otherwise a handshake empties the output.
    if (step) begin
      valid_d = 1'b1;
      idx_d   = IW'(N_CORE - 1) - j_q[IW-1:0];
      last_d  = last_step;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      j_q      <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      j_q      <= j_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_idx_o   = idx_q;

endmodule

// File: rtl/dnn_layer_seq.sv
// Layer sequencer: clears the cores, streams weight/data MACs plus bias, drains the FMA
// pipeline, then hands the out chain to dnn_out_drain for presentation through normalize.
module dnn_layer_seq
  import dnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          bank,
  input  logic [SW-1:0] in_size,
  input  logic [NW-1:0] n_out,
  output logic          busy,
  output logic          done,
  output logic          init,
  output logic          exec,
  output logic          bias,
  output logic [AW-1:0] ra,
  output logic [SW-1:0] da,
  output logic          outr,
  output logic          update,
  output logic          norm_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx
);

  localparam logic [SW-1:0] BIAS_WORD = SW'(F_SIZE - 1);

  seq_state_t    state_q, state_d;
  logic          bank_q, bank_d;
  logic [SW-1:0] size_q, size_d;
  logic [NW-1:0] nout_q, nout_d;
  logic [SW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          init_q, init_d;
  logic          exec_q, exec_d;
  logic          bias_q, bias_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [SW-1:0] da_q, da_d;

  logic          drain_start;
  logic          last_done;
  logic [SW-1:0] k_nxt;

  // Strobes and addresses are decoded from the next state so the cores see registered outputs.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    size_d      = size_q;
    nout_d      = nout_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    init_d      = 1'b0;
    exec_d      = 1'b0;
    bias_d      = 1'b0;
    ra_d        = '0;
    da_d        = '0;
    drain_start = 1'b0;
    k_nxt       = k_q + SW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          bank_d  = bank;
          size_d  = clamp_size(in_size);
          nout_d  = eff_n_out(n_out);
          init_d  = 1'b1;
        end
      end
      INIT: begin
        if (size_q == '0) begin
          state_d = BIAS;
          bias_d  = 1'b1;
          ra_d    = {bank_q, BIAS_WORD};
        end else begin
          state_d = RUN;
          exec_d  = 1'b1;
          k_d     = '0;
          ra_d    = {bank_q, {SW{1'b0}}};
          da_d    = '0;
        end
      end
      RUN: begin
        if (k_q == size_q - SW'(1)) begin
          state_d = BIAS;
          bias_d  = 1'b1;
          ra_d    = {bank_q, BIAS_WORD};
        end else begin
          exec_d = 1'b1;
          k_d    = k_nxt;
          ra_d   = {bank_q, k_nxt};
          da_d   = k_nxt;
        end
      end
      BIAS: begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: begin
        // The final MAC lands in the FMA on the third edge after issue.
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d     = OUT;
          drain_start = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUT: begin
        if (last_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
      size_q  <= '0;
      nout_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      exec_q  <= 1'b0;
      bias_q  <= 1'b0;
      ra_q    <= '0;
      da_q    <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      size_q  <= size_d;
      nout_q  <= nout_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      init_q  <= init_d;
      exec_q  <= exec_d;
      bias_q  <= bias_d;
      ra_q    <= ra_d;
      da_q    <= da_d;
    end
  end

  dnn_out_drain u_drain (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (drain_start),
    .n_out_i     (nout_q),
    .out_ready_i (out_ready),
    .norm_en_o   (norm_en),
    .outr_o      (outr),
    .update_o    (update),
    .out_valid_o (out_valid),
    .out_idx_o   (out_idx),
    .last_done_o (last_done)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign init = init_q;
  assign exec = exec_q;
  assign bias = bias_q;
  assign ra   = ra_q;
  assign da   = da_q;

endmodule

// File: tb/tb_dnn_layer_seq.sv
// Directed bench for dnn_layer_seq: table of layer runs with hand-computed timing and
// addresses, plus hand-written sequences for reset state and a reset abort during DRAIN.
module tb_dnn_layer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        bank;
  logic [9:0]  in_size;
  logic [4:0]  n_out;
  logic        busy, done, init, exec, bias;
  logic [10:0] ra;
  logic [9:0]  da;
  logic        outr, update, norm_en, out_valid, out_ready;
  logic [3:0]  out_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dnn_layer_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bank      (bank),
    .in_size   (in_size),
    .n_out     (n_out),
    .busy      (busy),
    .done      (done),
    .init      (init),
    .exec      (exec),
    .bias      (bias),
    .ra        (ra),
    .da        (da),
    .outr      (outr),
    .update    (update),
    .norm_en   (norm_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx)
  );

  typedef struct {
    logic        bank;
    int          in_size;
    int          n_out;
    int          stall_idx;    // out_idx at which out_ready is held low, -1 none
    int          stall_len;
    int          restart_cyc;  // cycle at which start is re-pulsed, -1 none
    int          exp_exec;
    logic [10:0] exp_bias_ra;
    int          exp_first_out;
    int          exp_outr;
    int          exp_words;
    int          exp_last_idx;
    int          exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle 0 is the cycle in which start is high; outputs are sampled 2 time units after each edge.
  task automatic run_layer(input vec_t v);
    int c = 0, k = 0, n_init = 0, n_bias = 0, n_norm = 0, n_upd = 0, n_outr = 0, n_words = 0;
    int first_out = -1, done_cyc = -1, last_idx = -1, stall_left = v.stall_len;
    logic [10:0] bias_ra = '0;

    @(posedge clk); #1;
    start = 1'b1; bank = v.bank; in_size = 10'(v.in_size); n_out = 5'(v.n_out); out_ready = 1'b1;
    #1;
    check("idle_busy_c0", 32'(busy), 32'd0);

    while (done_cyc < 0 && c < 300) begin
      @(posedge clk); #1;
      c++;
      // Inputs change after c0 to show the latched copies are used.
      start   = (c == v.restart_cyc);
      bank    = ~v.bank;
      in_size = 10'(v.in_size + 3);
      n_out   = 5'(v.n_out + 2);
      out_ready = 1'b1;
      if (stall_left > 0 && out_valid && int'(out_idx) == v.stall_idx) begin
        out_ready = 1'b0;
        stall_left--;
      end
      #1;
      if (c == 1) check("busy_c1", 32'(busy), 32'd1);
      if (init) n_init++;
      if (exec) begin
        check("exec_ra", 32'(ra), 32'({v.bank, 10'(k)}));
        check("exec_da", 32'(da), 32'(k));
        k++;
      end
      if (bias) begin
        n_bias++;
        bias_ra = ra;
      end
      if (update) n_upd++;
      if (norm_en) begin
        if (first_out < 0) first_out = c;
        check("update_first_only", 32'(update), 32'(n_norm == 0));
        n_norm++;
        if (outr) n_outr++;
      end
      if (out_valid && !out_ready) begin
        check("stall_norm_en", 32'(norm_en), 32'd0);
        check("stall_outr", 32'(outr), 32'd0);
        check("stall_idx", 32'(out_idx), 32'(v.stall_idx));
      end
      if (out_valid && out_ready) begin
        check("word_idx", 32'(out_idx), 32'(15 - n_words));
        last_idx = int'(out_idx);
        n_words++;
      end
      if (done) begin
        done_cyc = c;
        check("done_busy_low", 32'(busy), 32'd0);
      end
    end

    check("init_count", 32'(n_init), 32'd1);
    check("exec_count", 32'(k), 32'(v.exp_exec));
    check("bias_count", 32'(n_bias), 32'd1);
    check("bias_ra", 32'(bias_ra), 32'(v.exp_bias_ra));
    check("first_norm_en_cyc", 32'(first_out), 32'(v.exp_first_out));
    check("update_count", 32'(n_upd), 32'd1);
    check("outr_count", 32'(n_outr), 32'(v.exp_outr));
    check("word_count", 32'(n_words), 32'(v.exp_words));
    check("last_idx", 32'(last_idx), 32'(v.exp_last_idx));
    check("done_cyc", 32'(done_cyc), 32'(v.exp_done));

    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int n_done;

    //            bank in  nout stl len rst exec bias_ra  fo  outr wrd last done
    vecs[0] = '{1'b0, 3, 1,  -1, 0, -1, 3, 11'h3FF, 9,  0,  1,  15, 11};
    vecs[1] = '{1'b1, 0, 1,  -1, 0, -1, 0, 11'h7FF, 6,  0,  1,  15, 8};
    vecs[2] = '{1'b0, 2, 4,  -1, 0, -1, 2, 11'h3FF, 8,  3,  4,  12, 13};
    vecs[3] = '{1'b1, 1, 3,  14, 2, -1, 1, 11'h7FF, 7,  2,  3,  13, 13};
    vecs[4] = '{1'b0, 5, 0,  -1, 0, -1, 5, 11'h3FF, 11, 0,  1,  15, 13};
    vecs[5] = '{1'b0, 1, 16, -1, 0, -1, 1, 11'h3FF, 7,  15, 16, 0,  24};
    vecs[6] = '{1'b0, 4, 1,  -1, 0, 3,  4, 11'h3FF, 10, 0,  1,  15, 12};

    rst_n = 1'b0; start = 1'b0; bank = 1'b0; in_size = '0; n_out = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_strobes", 32'({busy, done, init, exec, bias, outr, update, norm_en, out_valid}), 32'd0);
    check("rst_ra", 32'(ra), 32'd0);
    check("rst_da", 32'(da), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_layer(vecs[i]);

    // Reset asserted in DRAIN: in_size=2 gives drain in cycles 5..7; reset driven in cycle 6.
    @(posedge clk); #1;
    start = 1'b1; bank = 1'b1; in_size = 10'd2; n_out = 5'd2; out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("abort_strobes", 32'({busy, done, init, exec, bias, outr, update, norm_en, out_valid}), 32'd0);
    check("abort_ra", 32'(ra), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (done || busy || norm_en) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);

    run_layer(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
